// File: rtl/seq_detector_prog.sv
// ============================================================================
//  Module   : seq_detector_prog
//  Brief    : Runtime-programmable serial pattern detector (1..MAX_LEN bits)
//             with overlap select, input qualifier, Moore match pulse and
//             saturating match counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               din,
    input  logic               din_valid,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    input  logic               clr_count,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_FILL     = 2'd1,
        ST_HUNT     = 2'd2
    } state_t;

    localparam logic [MAX_LEN-1:0] c_DEF_PATTERN = MAX_LEN'(4'b1010);
    localparam logic [LEN_W-1:0]   c_DEF_LEN     = LEN_W'(4);
    localparam logic [LEN_W-1:0]   c_MAX_LEN     = LEN_W'(MAX_LEN);

    state_t             r_state,   w_state_nxt;
    logic [MAX_LEN-1:0] r_pattern, w_pattern_nxt;
    logic [LEN_W-1:0]   r_len,     w_len_nxt;
    logic               r_overlap, w_overlap_nxt;
    logic [MAX_LEN-1:0] r_hist,    w_hist_nxt;
    logic [LEN_W-1:0]   r_fill,    w_fill_nxt;
    logic               r_match,   w_match_nxt;
    logic [CNT_W-1:0]   r_count,   w_count_nxt;
    logic               r_cfg_err, w_cfg_err_nxt;

    logic               w_accept;
    logic [MAX_LEN-1:0] w_hist_shift;
    logic [LEN_W-1:0]   w_fill_inc;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_hit;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_cfg_bad;

    // Datapath: the hit is judged on the post-shift history, so the pulse
    // registers on the same edge that samples the final pattern bit.
    always_comb begin
        w_accept     = din_valid && !cfg_load && (r_state != ST_DISABLED);
        w_hist_shift = {r_hist[MAX_LEN-2:0], din};
        w_fill_inc   = (r_fill < r_len) ? r_fill + LEN_W'(1) : r_fill;
        w_mask       = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
        w_hit     = w_accept && (w_fill_inc >= r_len) &&
                    (((w_hist_shift ^ r_pattern) & w_mask) == '0);
        w_cnt_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);
        w_cfg_bad = (cfg_len == '0) || (cfg_len > c_MAX_LEN);
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pattern_nxt = r_pattern;
        w_len_nxt     = r_len;
        w_overlap_nxt = r_overlap;
        w_hist_nxt    = r_hist;
        w_fill_nxt    = r_fill;
        w_match_nxt   = 1'b0;
        w_count_nxt   = r_count;
        w_cfg_err_nxt = r_cfg_err;

        if (cfg_load) begin
            w_pattern_nxt = cfg_pattern;
            w_len_nxt     = cfg_len;
            w_overlap_nxt = cfg_overlap;
            w_hist_nxt    = '0;
            w_fill_nxt    = '0;
            w_count_nxt   = '0;
            w_cfg_err_nxt = w_cfg_bad;
            w_state_nxt   = w_cfg_bad ? ST_DISABLED : ST_FILL;
        end else begin
            if (w_accept) begin
                w_hist_nxt  = w_hist_shift;
                w_fill_nxt  = w_fill_inc;
                w_state_nxt = (w_fill_inc == r_len) ? ST_HUNT : ST_FILL;
            end
            if (w_hit) begin
                w_match_nxt = 1'b1;
                w_count_nxt = clr_count ? CNT_W'(1) : w_cnt_inc;
                // Non-overlap restarts from empty so matched bits are not reused.
                if (!r_overlap) begin
                    w_hist_nxt  = '0;
                    w_fill_nxt  = '0;
                    w_state_nxt = ST_FILL;
                end
            end else if (clr_count) begin
                w_count_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FILL;
            r_pattern <= c_DEF_PATTERN;
            r_len     <= c_DEF_LEN;
            r_overlap <= 1'b1;
            r_hist    <= '0;
            r_fill    <= '0;
            r_match   <= 1'b0;
            r_count   <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pattern <= w_pattern_nxt;
            r_len     <= w_len_nxt;
            r_overlap <= w_overlap_nxt;
            r_hist    <= w_hist_nxt;
            r_fill    <= w_fill_nxt;
            r_match   <= w_match_nxt;
            r_count   <= w_count_nxt;
            r_cfg_err <= w_cfg_err_nxt;
        end
    end

    assign match       = r_match;
    assign match_count = r_count;
    assign cfg_err     = r_cfg_err;

endmodule

`default_nettype wire
